// File: rtl/bf16_pkg.sv
// Shared bfloat16 format constants and pipeline payload types.
// Optional IEEE special-value decoding: BF16_MUL_SPECIAL_EN.
package bf16_pkg;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_INF  = 16'h7F80;
    localparam logic [15:0] BF16_MAXF = 16'h7F7F;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } bf16_t;

    // Without special decoding only the flush-to-zero flag exists.
    typedef struct packed {
        logic zero;
`ifdef BF16_MUL_SPECIAL_EN
        logic inf;
        logic nan;
`endif
    } bf16_flags_t;

    typedef struct packed {
        logic               sign;
        logic signed [9:0]  exp;
        logic [15:0]        prod;
        bf16_flags_t        flags;
    } bf16_mul_s1_t;

endpackage

// File: rtl/bf16_mul_pipe_if.sv
// Operand/result handshake bundle for the bf16 multiplier.
interface bf16_mul_pipe_if;

    logic [15:0] a;
    logic        a_vld;
    logic [15:0] b;
    logic        b_vld;
    logic        in_rdy;
    logic [15:0] z;
    logic        z_vld;
    logic        z_rdy;

    modport master (
        output a, a_vld, b, b_vld, z_rdy,
        input  in_rdy, z, z_vld
    );

    modport slave (
        input  a, a_vld, b, b_vld, z_rdy,
        output in_rdy, z, z_vld
    );

endinterface

// File: rtl/bf16_round_pack.sv
// Combinational normalize, round-to-nearest-even and pack of a raw bf16 product.
// Special-value handling compiled in with BF16_MUL_SPECIAL_EN.
module bf16_round_pack
    import bf16_pkg::*;
(
    input  bf16_mul_s1_t s1,
    output logic [15:0]  z
);

    function automatic logic [8:0] rne_round(input logic [7:0] sig, input logic g,
                                             input logic r, input logic st);
        return {1'b0, sig} + {8'b0, g && (r || st || sig[0])};
    endfunction

    function automatic logic [15:0] sat_overflow(input logic s);
`ifdef BF16_MUL_SPECIAL_EN
        return {s, BF16_INF[14:0]};
`else
        return {s, BF16_MAXF[14:0]};
`endif
    endfunction

    logic               norm;
    logic [7:0]         sig;
    logic               grd;
    logic               rnd_bit;
    logic               sticky;
    logic signed [9:0]  exp_n;
    logic [8:0]         rnd;
    logic signed [9:0]  exp_r;
    logic [6:0]         frac;

    always_comb begin
        norm    = s1.prod[15];
        sig     = norm ? s1.prod[15:8] : s1.prod[14:7];
        grd     = norm ? s1.prod[7]    : s1.prod[6];
        rnd_bit = norm ? s1.prod[6]    : s1.prod[5];
        sticky  = norm ? |s1.prod[5:0] : |s1.prod[4:0];
        exp_n   = s1.exp + $signed({9'b0, norm});
        rnd     = rne_round(sig, grd, rnd_bit, sticky);
        // A carry out of rounding leaves 1.0000000 x 2, so shift and bump the exponent.
        exp_r   = exp_n + $signed({9'b0, rnd[8]});
        frac    = rnd[8] ? rnd[7:1] : rnd[6:0];

        z = {s1.sign, exp_r[7:0], frac};
        if (exp_r >= 10'sd255)
            z = sat_overflow(s1.sign);
        else if (exp_r <= 10'sd0)
            z = {s1.sign, 15'h0000};

        if (s1.flags.zero)
            z = {s1.sign, 15'h0000};
`ifdef BF16_MUL_SPECIAL_EN
        if (s1.flags.inf)
            z = {s1.sign, BF16_INF[14:0]};
        if (s1.flags.nan)
            z = BF16_QNAN;
`endif
    end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Two-stage pipelined bfloat16 multiplier with valid/ready flow control.
// Define BF16_MUL_SPECIAL_EN for IEEE NaN/Inf decoding and overflow to infinity.
module bf16_mul_pipe
    import bf16_pkg::*;
(
    input logic            clk,
    input logic            rst,
    bf16_mul_pipe_if.slave bus
);

    localparam logic signed [9:0] BIAS_W = 10'(BF16_BIAS);

    logic         adv;
    logic         acc;
    bf16_t        a_f;
    bf16_t        b_f;
    logic         a_zero;
    logic         b_zero;
    logic [7:0]   ma;
    logic [7:0]   mb;
    bf16_mul_s1_t s1_d;
    bf16_mul_s1_t s1_p1;
    logic         vld_p1;
    logic [15:0]  z_d;
    logic [15:0]  z_p2;
    logic         vld_p2;

    // The whole pipe moves together; a held output freezes every stage.
    assign adv        = !vld_p2 || bus.z_rdy;
    assign acc        = bus.a_vld && bus.b_vld && adv;
    assign bus.in_rdy = adv;
    assign bus.z      = z_p2;
    assign bus.z_vld  = vld_p2;

    // Stage 0 -> 1: unpack, exponent sum, significand product, special flags
    assign a_f    = bus.a;
    assign b_f    = bus.b;
    assign a_zero = (a_f.e == 8'h00);
    assign b_zero = (b_f.e == 8'h00);
    assign ma     = {1'b1, a_f.m};
    assign mb     = {1'b1, b_f.m};

    always_comb begin
        s1_d.sign       = a_f.s ^ b_f.s;
        s1_d.exp        = $signed({2'b00, a_f.e}) + $signed({2'b00, b_f.e}) - BIAS_W;
        s1_d.prod       = {8'b0, ma} * {8'b0, mb};
        s1_d.flags.zero = a_zero || b_zero;
`ifdef BF16_MUL_SPECIAL_EN
        s1_d.flags.nan  = ((a_f.e == 8'hFF) && (a_f.m != 7'h00))
                       || ((b_f.e == 8'hFF) && (b_f.m != 7'h00))
                       || (((a_f.e == 8'hFF) || (b_f.e == 8'hFF)) && (a_zero || b_zero));
        s1_d.flags.inf  = ((a_f.e == 8'hFF) || (b_f.e == 8'hFF)) && !s1_d.flags.nan;
`endif
    end

    always_ff @(posedge clk) begin
        if (adv)
            s1_p1 <= s1_d;
    end

    // Stage 1 -> 2: normalize, round, pack into the output register
    bf16_round_pack u_round_pack (
        .s1 (s1_p1),
        .z  (z_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            z_p2   <= 16'h0000;
        end else if (adv) begin
            vld_p1 <= acc;
            vld_p2 <= vld_p1;
            if (vld_p1)
                z_p2 <= z_d;
        end
    end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Directed bench for bf16_mul_pipe with a scoreboard fed by an integer-arithmetic model.
module tb_bf16_mul_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bf16_mul_pipe_if bus ();

    bf16_mul_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
    } vec_t;
    vec_t tbl[$];

    // Product from the real-number definition: exact integer significand product,
    // rounded to 8 significant bits with ties to even.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int ex = int'(x[14:7]);
        int ey = int'(y[14:7]);
        int mx = int'(x[6:0]);
        int my = int'(y[6:0]);
        logic s = x[15] ^ y[15];
        int p, e, sh, q, r, half;
`ifdef BF16_MUL_SPECIAL_EN
        if ((ex == 255 && mx != 0) || (ey == 255 && my != 0)) return 16'h7FC0;
        if (ex == 255 || ey == 255) begin
            if (ex == 0 || ey == 0) return 16'h7FC0;
            return {s, 15'h7F80};
        end
`endif
        if (ex == 0 || ey == 0) return {s, 15'h0000};
        p  = (128 + mx) * (128 + my);
        e  = ex + ey - 127;
        sh = 7;
        if (p >= 32768) begin
            sh = 8;
            e++;
        end
        q    = p >> sh;
        r    = p - (q << sh);
        half = 1 << (sh - 1);
        if (r > half || (r == half && q[0])) q++;
        if (q == 256) begin
            q = 128;
            e++;
        end
`ifdef BF16_MUL_SPECIAL_EN
        if (e >= 255) return {s, 15'h7F80};
`else
        if (e >= 255) return {s, 15'h7F7F};
`endif
        if (e <= 0) return {s, 15'h0000};
        return {s, e[7:0], q[6:0]};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on consume; reset discards in-flight work.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.z_vld && bus.z_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_z: got z=%h with z_vld=1, expected no output", bus.z);
                end else begin
                    check16("stream", bus.z, exp_q.pop_front());
                end
            end
            if (bus.a_vld && bus.b_vld && bus.in_rdy)
                exp_q.push_back(ref_mul(bus.a, bus.b));
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        bit ok = 1'b0;
        bus.a = x;
        bus.b = y;
        bus.a_vld = 1'b1;
        bus.b_vld = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_rdy;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: in_rdy=0 for 50 cycles, expected 1");
        end
    endtask

    task automatic idle();
        bus.a_vld = 1'b0;
        bus.b_vld = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (6) @(posedge clk);
        #1;
        check16("queue_empty", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        bus.a_vld = 1'b0;
        bus.b_vld = 1'b0;
        bus.z_rdy = 1'b1;
        rst = 1'b1;

        tbl.push_back('{16'h3F80, 16'h3F80, 16'h3F80});
        tbl.push_back('{16'hC000, 16'h4040, 16'hC0C0});
        tbl.push_back('{16'h3FC0, 16'h3FC0, 16'h4010});
        tbl.push_back('{16'h3F88, 16'h3F88, 16'h3F90});
        tbl.push_back('{16'h3F81, 16'h3F81, 16'h3F82});
        tbl.push_back('{16'h0080, 16'h0080, 16'h0000});
        tbl.push_back('{16'h0001, 16'h3F80, 16'h0000});
        tbl.push_back('{16'h8001, 16'h3F80, 16'h8000});
        tbl.push_back('{16'hBF80, 16'h4000, 16'hC000});
        tbl.push_back('{16'h3F80, 16'h4040, 16'h4040});
`ifdef BF16_MUL_SPECIAL_EN
        tbl.push_back('{16'h7F00, 16'h7F00, 16'h7F80});
        tbl.push_back('{16'hFF00, 16'h7F00, 16'hFF80});
        tbl.push_back('{16'h7FC1, 16'h3F80, 16'h7FC0});
        tbl.push_back('{16'h7F80, 16'h0000, 16'h7FC0});
        tbl.push_back('{16'h7F80, 16'hBF80, 16'hFF80});
`else
        tbl.push_back('{16'h7F00, 16'h7F00, 16'h7F7F});
        tbl.push_back('{16'hFF00, 16'h7F00, 16'hFF7F});
        tbl.push_back('{16'h7F80, 16'h3F80, 16'h7F7F});
`endif

        repeat (2) @(posedge clk);
        #1;
        check16("reset_z_vld", {15'b0, bus.z_vld}, 16'd0);
        check16("reset_z", bus.z, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check16("reset_in_rdy", {15'b0, bus.in_rdy}, 16'd1);
        @(posedge clk);
        #1;

        // Latency: result visible exactly two cycles after the accepting edge.
        issue(16'h3F80, 16'h3F80);
        idle();
        @(negedge clk);
        check16("lat_cycle1_z_vld", {15'b0, bus.z_vld}, 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check16("lat_cycle2_z_vld", {15'b0, bus.z_vld}, 16'd1);
        check16("lat_cycle2_z", bus.z, 16'h3F80);
        drain();

        // Only one operand valid: nothing may be accepted.
        bus.a = 16'h4000;
        bus.a_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.a_vld = 1'b0;
        bus.b_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drain();

        // Directed table: pin the model, then stream back-to-back through the DUT.
        foreach (tbl[i]) check16("model_pin", ref_mul(tbl[i].a, tbl[i].b), tbl[i].z);
        foreach (tbl[i]) issue(tbl[i].a, tbl[i].b);
        drain();

        // Back-to-back issue gives results on consecutive cycles.
        issue(16'hC000, 16'h4040);
        issue(16'h3FC0, 16'h3FC0);
        idle();
        @(negedge clk);
        check16("b2b_first_vld", {15'b0, bus.z_vld}, 16'd1);
        check16("b2b_first_z", bus.z, 16'hC0C0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check16("b2b_second_vld", {15'b0, bus.z_vld}, 16'd1);
        check16("b2b_second_z", bus.z, 16'h4010);
        drain();

        // Stall with three pairs: output and stage 1 hold, in_rdy low, no loss.
        bus.z_rdy = 1'b0;
        issue(16'h3F80, 16'h4000);
        issue(16'h4040, 16'h4040);
        held = ref_mul(16'h3F80, 16'h4000);
        bus.a = 16'hC000;
        bus.b = 16'h3F00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check16("stall_z", bus.z, held);
            check16("stall_z_vld", {15'b0, bus.z_vld}, 16'd1);
            check16("stall_in_rdy", {15'b0, bus.in_rdy}, 16'd0);
            @(posedge clk);
            #1;
        end
        bus.z_rdy = 1'b1;
        issue(16'hC000, 16'h3F00);
        drain();

        // Reset with two products in flight: both discarded.
        bus.z_rdy = 1'b0;
        issue(16'h3FC0, 16'h3FC0);
        issue(16'hC000, 16'h4040);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check16("midreset_z_vld", {15'b0, bus.z_vld}, 16'd0);
        check16("midreset_z", bus.z, 16'h0000);
        rst = 1'b0;
        bus.z_rdy = 1'b1;
        drain();
        @(negedge clk);
        check16("post_reset_in_rdy", {15'b0, bus.in_rdy}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
